// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit seven-segment driver for an MM:SS stopwatch.
// Pipeline: capture/clamp -> BCD split -> registered segment/anode/dp outputs.
module stopwatch_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_OFF      = 7'b1111111;

    // Tens digit of a value already clamped to 0..59.
    function automatic logic [2:0] tens_of(input logic [5:0] v);
        if (v >= 6'd50)      return 3'd5;
        else if (v >= 6'd40) return 3'd4;
        else if (v >= 6'd30) return 3'd3;
        else if (v >= 6'd20) return 3'd2;
        else if (v >= 6'd10) return 3'd1;
        else                 return 3'd0;
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_OFF;
        endcase
    endfunction

    logic [5:0]    sec_cap, min_cap;
    logic [2:0]    sec_tens, min_tens;
    logic [3:0]    sec_ones, min_ones;
    logic [2:0]    sec_tens_next, min_tens_next;
    logic [3:0]    sec_ones_next, min_ones_next;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;
    logic          dp_next;

    // Stage 1: capture with clamp to 59.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of its source, which keeps the pipeline stages
    // one cycle apart regardless of block ordering.
    always_ff @(posedge clk1) begin
        if (rst) begin
            sec_cap <= '0;
            min_cap <= '0;
        end else begin
            sec_cap <= (seconds > 6'd59) ? 6'd59 : seconds;
            min_cap <= (minutes > 6'd59) ? 6'd59 : minutes;
        end
    end

    always_comb begin
        sec_tens_next = tens_of(sec_cap);
        min_tens_next = tens_of(min_cap);
        sec_ones_next = 4'(sec_cap - 6'd10 * {3'b000, sec_tens_next});
        min_ones_next = 4'(min_cap - 6'd10 * {3'b000, min_tens_next});
    end

    // Stage 2: BCD registers.
    always_ff @(posedge clk1) begin
        if (rst) begin
            sec_tens <= '0;
            sec_ones <= '0;
            min_tens <= '0;
            min_ones <= '0;
        end else begin
            sec_tens <= sec_tens_next;
            sec_ones <= sec_ones_next;
            min_tens <= min_tens_next;
            min_ones <= min_ones_next;
        end
    end

    // Digit scan: the index advances once per full refresh period.
    always_ff @(posedge clk1) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Blink timebase only runs in adjust mode; leaving adjust parks it at zero.
    always_ff @(posedge clk1) begin
        if (rst || !adj) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // adj and sel are used live so field switches and exiting adjust act on
    // the very next output update.
    // NOTE: every always_comb output gets a value on every path (here via the
    // default arm) so no latch is inferred.
    always_comb begin
        case (digit_idx)
            2'd0:    digit = sec_ones;
            2'd1:    digit = {1'b0, sec_tens};
            2'd2:    digit = min_ones;
            default: digit = {1'b0, min_tens};
        endcase
        blank    = adj && blink_phase && (sel ? !digit_idx[1] : digit_idx[1]);
        seg_next = blank ? SEG_OFF : encode(digit);
        an_next  = ~(4'b0001 << digit_idx);
        dp_next  = (digit_idx != 2'd2);
    end

    // Stage 3: registered outputs, all dark during reset.
    always_ff @(posedge clk1) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= 4'b1111;
            dp  <= 1'b1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display against a time-based reference model
// (slot from elapsed cycles, blink phase from adjust run length, 2-edge input lag).
module tb_stopwatch_display;

    localparam int RD = 4;
    localparam int BD = 8;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] seconds = '0;
    logic [5:0] minutes = '0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int checks = 0;
    int failures = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reference model state
    int         since_rst = 0;
    int         adj_run = 0;
    int         p1s = 0, p1m = 0, p2s = 0, p2m = 0;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_dp;

    always #5 clk1 = ~clk1;

    stopwatch_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk1(clk1), .rst(rst), .seconds(seconds), .minutes(minutes),
        .adj(adj), .sel(sel), .seg(seg), .an(an), .dp(dp)
    );

    function automatic int clamp59(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    // One clock edge: predict outputs from the inputs seen at this edge, then settle.
    task automatic advance();
        int idx, phase, val;
        bit blank;
        @(posedge clk1);
        if (rst) begin
            exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
            since_rst = 0; adj_run = 0;
            p1s = 0; p1m = 0; p2s = 0; p2m = 0;
        end else begin
            idx   = (since_rst / RD) % 4;
            phase = (adj_run / BD) % 2;
            case (idx)
                0: val = p2s % 10;
                1: val = p2s / 10;
                2: val = p2m % 10;
                default: val = p2m / 10;
            endcase
            blank   = adj && (phase == 1) && (sel ? (idx < 2) : (idx >= 2));
            exp_an  = an_tab[idx];
            exp_seg = blank ? 7'b1111111 : seg_tab[val];
            exp_dp  = (idx == 2) ? 1'b0 : 1'b1;
            since_rst++;
            adj_run = adj ? adj_run + 1 : 0;
            p2s = p1s; p2m = p1m;
            p1s = clamp59(int'(seconds)); p1m = clamp59(int'(minutes));
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; adj = 1'b1; sel = 1'b1;
        seconds = 6'($urandom_range(0, 63)); minutes = 6'($urandom_range(0, 63));
        for (int i = 0; i < 3; i++) begin
            advance();
            if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", i, an, seg, dp);
            end
            checks++;
        end
        rst = 1'b0;
        advance();
        if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
            failures++;
            $display("FAIL reset_release got an=%b seg=%b dp=%b want an=1110 seg=1000000 dp=1", an, seg, dp);
        end
        checks++;
    endtask

    task automatic test_scan();
        int exp_digit [4] = '{7, 3, 2, 1};
        int slot;
        rst = 1'b1; seconds = 6'd37; minutes = 6'd12; adj = 1'b0; sel = 1'b0;
        advance();
        rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            advance();
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL scan cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            checks++;
            if (n >= 3 && (n % 4 == 1 || n == 3)) begin
                slot = ((n - 1) / RD) % 4;
                if ({an, seg, dp} !== {an_tab[slot], seg_tab[exp_digit[slot]], (slot == 2) ? 1'b0 : 1'b1}) begin
                    failures++;
                    $display("FAIL scan_fixed cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b", n, an, seg, dp, an_tab[slot], seg_tab[exp_digit[slot]]);
                end
                checks++;
            end
        end
    endtask

    task automatic test_clamp();
        seconds = 6'd63; minutes = 6'd60; adj = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            advance();
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL clamp cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            checks++;
            if (n >= 3 && seg !== seg_tab[5] && seg !== seg_tab[9]) begin
                failures++;
                $display("FAIL clamp_59 cyc=%0d got seg=%b want 0010010 or 0010000", n, seg);
            end
            if (n >= 3) checks++;
            if (n % 3 == 0) begin
                seconds = 6'($urandom_range(60, 63));
                minutes = 6'($urandom_range(60, 63));
            end
        end
    endtask

    task automatic test_blink();
        rst = 1'b1; seconds = 6'd42; minutes = 6'd5; adj = 1'b1; sel = 1'b1;
        advance();
        rst = 1'b0;
        for (int n = 1; n <= 48; n++) begin
            advance();
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL blink cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            checks++;
            if (n >= 3 && ((an === 4'b1011 && seg !== seg_tab[5]) || (an === 4'b0111 && seg !== seg_tab[0]))) begin
                failures++;
                $display("FAIL blink_minutes cyc=%0d got an=%b seg=%b want minutes 05 unblanked", n, an, seg);
            end
            if (n >= 3 && (an === 4'b1011 || an === 4'b0111)) checks++;
        end
    endtask

    task automatic test_field_switch();
        int waited = 0;
        adj = 1'b1; sel = 1'b1;
        while (((adj_run / BD) % 2) != 1 && waited < 64) begin
            advance();
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL field_wait got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            checks++;
            waited++;
        end
        if (waited >= 64) begin
            failures++;
            $display("FAIL field_wait_timeout got waited=%0d want <64", waited);
        end
        checks++;
        sel = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            advance();
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL field_switch cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            checks++;
        end
    endtask

    task automatic test_mid_reset();
        int waited = 0;
        adj = 1'b1; sel = 1'b0;
        seconds = 6'($urandom_range(0, 59)); minutes = 6'($urandom_range(0, 59));
        while (exp_an !== 4'b1011 && waited < 64) begin
            advance();
            waited++;
        end
        if (waited >= 64) begin
            failures++;
            $display("FAIL mid_reset_wait_timeout got waited=%0d want <64", waited);
        end
        checks++;
        rst = 1'b1;
        advance();
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset_off got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        checks++;
        rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            advance();
            if (n <= RD && an !== 4'b1110) begin
                failures++;
                $display("FAIL mid_reset_restart cyc=%0d got an=%b want an=1110", n, an);
            end
            if (n <= RD) checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL mid_reset cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int n = 1; n <= 600; n++) begin
            if ($urandom_range(0, 3) == 0) seconds = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) minutes = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            if ($urandom_range(0, 15) == 0) sel = ~sel;
            rst = ($urandom_range(0, 99) == 0);
            advance();
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL random cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            checks++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_clamp();
        test_blink();
        test_field_switch();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 The parameters SHALL be:
- REFRESH_DIV, 100000, clk1 cycles per digit slot (>=2).
- BLINK_DIV, 25000000, clk1 cycles per blink half-period (>=2).

REQ-002 The ports SHALL be (clock and reset first):
- clk1  in  1  block clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- seconds  in  6  binary seconds from the counting stage.
- minutes  in  6  binary minutes from the counting stage.
- adj  in  1  adjust mode active.
- sel  in  1  adjust field select (0 = minutes, 1 = seconds).
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit anodes, active-low.
- dp  out  1  decimal point, active-low.

REQ-003 Reset SHALL be rst, synchronous, active-high, and the clock SHALL be clk1.

Function
REQ-004 seconds and minutes SHALL be registered into capture registers every cycle, and any value >59 SHALL be clamped to 59.

REQ-005 Each captured value SHALL be converted to BCD tens (0-5) and ones (0-9) in a registered stage.

REQ-006 All outputs SHALL be registered, giving 3 cycles from an input change to seg on an active slot.

REQ-007 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; digit index (2 bits) SHALL increment, modulo 4, on each wrap.

REQ-008 The digit index SHALL map as follows:
- 0 -> an=1110, seconds ones.
- 1 -> an=1101, seconds tens.
- 2 -> an=1011, minutes ones.
- 3 -> an=0111, minutes tens.

REQ-009 Exactly one anode SHALL be low in every cycle outside reset.

REQ-010 The digit encoding (seg, active-low) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

REQ-011 dp SHALL be 0 only while digit index = 2 (minutes/seconds separator), and 1 otherwise.

REQ-012 While adj=1, a blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on each wrap.

REQ-013 While adj=0, the blink counter and blink_phase SHALL be held at 0.

REQ-014 When adj=1 and blink_phase=1, digits of the selected field SHALL output seg=1111111, with the anode still driven per REQ-008:
- sel=1 blanks digits 0-1.
- sel=0 blanks digits 2-3.

REQ-015 The unselected field SHALL always display normally.

REQ-016 A sel change while adj=1 SHALL move blanking to the new field from the next output register update, without resetting the blink counter.

REQ-017 An adj 1->0 transition SHALL unblank all digits from the next output register update.

REQ-018 Input changes SHALL NOT disturb the refresh counter or digit index.

Reset
REQ-019 While rst=1, the following SHALL be forced:
- refresh counter 0, digit index 0.
- blink counter 0, blink_phase 0.
- capture and BCD registers 0.
- an=1111, seg=1111111, dp=1.

REQ-020 In the first cycle after rst deasserts, outputs SHALL be an=1110, seg=1000000 (zero), dp=1.

REQ-021 Assertion of rst mid-scan or mid-blink SHALL take effect at the next clk1 edge, regardless of adj or sel.

Verification
(All scenarios use REFRESH_DIV=4, BLINK_DIV=8.)

REQ-022 Scan: reset, then seconds=37, minutes=12, adj=0 for 16 cycles -> the following sequence, each slot 4 cycles, then repeating:
- an=1110 seg=1111000 (7).
- an=1101 seg=0110000 (3).
- an=1011 seg=0100100 (2), dp=0.
- an=0111 seg=1111001 (1).

REQ-023 Clamp: seconds=63, minutes=60 -> every digit slot displays 5 or 9, i.e. 59:59.

REQ-024 Blink: adj=1, sel=1, time 05:42 -> digits 0-1 alternate normal/1111111 every 8 cycles, and digits 2-3 are always 0 and 5.

REQ-025 Field switch: with adj=1, toggle sel 1->0 while blink_phase=1 -> next update blanks digits 2-3, digits 0-1 resume, and the blink counter is not restarted.

REQ-026 Mid-operation reset: assert rst for 1 cycle during digit 2 with adj=1 -> outputs all-off that cycle, then an=1110 with digit index, refresh and blink restarted from 0.
